bin2bcd_seq: RTL

//  Sequential shift-add-3 (double-dabble) binary-to-BCD converter.

---
 rtl/seg_pkg.sv | 14 +
 rtl/bcd_dabble_digit.sv | 12 +
 rtl/bin2bcd_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the count-display pipeline: converter FSM states and
// BCD digit constants.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int              BCD_W    = 4;
    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_dabble_digit.sv
// Combinational double-dabble digit correction: a digit of 5 or more gets 3
// added so the following left shift carries correctly into the next digit.
module bcd_dabble_digit
    import seg_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] adj
);

    assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake.
// One guard digit above the presented digits detects values that do not fit.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int INT_DIGITS = DIGITS + 1;
    localparam int ACC_W      = BCD_W * INT_DIGITS;
    localparam int SR_W       = ACC_W + BIN_W;
    localparam int CNT_W      = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t             state, state_nx;
    logic [ACC_W-1:0]   acc, acc_adj, acc_sh;
    logic [BIN_W-1:0]   bin_sr, bin_sh;
    logic [SR_W-1:0]    sr_sh;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   guard;
    logic               load, shift_en, capture;

    for (genvar g = 0; g < INT_DIGITS; g++) begin : g_digit
        bcd_dabble_digit u_adj (
            .digit (acc[g*BCD_W +: BCD_W]),
            .adj   (acc_adj[g*BCD_W +: BCD_W])
        );
    end

    assign sr_sh  = {acc_adj, bin_sr} << 1;
    assign acc_sh = sr_sh[SR_W-1:BIN_W];
    assign bin_sh = sr_sh[BIN_W-1:0];
    assign guard  = acc_sh[ACC_W-1 -: BCD_W];

    // NOTE: every signal written here gets a default first so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift_en = 1'b0;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (cnt == LAST_CNT) begin
                    capture  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = ST_SHIFT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            bin_sr <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            bin_sr <= bin;
            cnt    <= '0;
        end else if (shift_en) begin
            acc    <= acc_sh;
            bin_sr <= bin_sh;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Results are captured from the final shift so they appear with DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd      <= '0;
            overflow <= 1'b0;
        end else if (capture) begin
            if (guard != '0) begin
                bcd      <= {DIGITS{BCD_NINE}};
                overflow <= 1'b1;
            end else begin
                bcd      <= acc_sh[BCD_W*DIGITS-1:0];
                overflow <= 1'b0;
            end
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule
